// File: rtl/tea_pkg.sv
// Shared TEA definitions: constants, FSM states, block/key packing and the round mixing function.
package tea_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 128;

  localparam logic [WORD_W-1:0] TEA_DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] v0;
    logic [WORD_W-1:0] v1;
  } tea_block_t;

  typedef struct packed {
    logic [WORD_W-1:0] k0;
    logic [WORD_W-1:0] k1;
    logic [WORD_W-1:0] k2;
    logic [WORD_W-1:0] k3;
  } tea_key_t;

  // F(v) = ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb), logical shifts, mod 2^32
  function automatic logic [WORD_W-1:0] tea_f(input logic [WORD_W-1:0] v,
                                              input logic [WORD_W-1:0] ka,
                                              input logic [WORD_W-1:0] kb,
                                              input logic [WORD_W-1:0] sum);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round_step.sv
// One combinational TEA round (encrypt or decrypt), chained RPC times by the engine.
module tea_round_step
  import tea_pkg::*;
#(
  parameter logic [WORD_W-1:0] DELTA = TEA_DELTA
) (
  input  logic [BLOCK_W-1:0] v_in,
  input  logic [WORD_W-1:0]  sum_in,
  input  logic [KEY_W-1:0]   key,
  input  logic               mode,
  output logic [BLOCK_W-1:0] v_out,
  output logic [WORD_W-1:0]  sum_out
);

  tea_block_t        b_in;
  tea_block_t        b_out;
  tea_key_t          k;
  logic [WORD_W-1:0] sum_enc;

  // Encrypt advances sum first; decrypt uses the current sum and retreats it afterwards
  always_comb begin
    b_in    = tea_block_t'(v_in);
    k       = tea_key_t'(key);
    sum_enc = sum_in + DELTA;
    b_out   = b_in;
    sum_out = sum_in;
    if (!mode) begin
      b_out.v0 = b_in.v0 + tea_f(b_in.v1, k.k0, k.k1, sum_enc);
      b_out.v1 = b_in.v1 + tea_f(b_out.v0, k.k2, k.k3, sum_enc);
      sum_out  = sum_enc;
    end else begin
      b_out.v1 = b_in.v1 - tea_f(b_in.v0, k.k2, k.k3, sum_in);
      b_out.v0 = b_in.v0 - tea_f(b_out.v1, k.k0, k.k1, sum_in);
      sum_out  = sum_in - DELTA;
    end
    v_out = b_out;
  end

endmodule

// File: rtl/tea_cipher_engine.sv
// Iterative TEA engine: valid/ready request in, ROUNDS/RPC clocks of RPC unrolled rounds, held result out.
module tea_cipher_engine
  import tea_pkg::*;
#(
  parameter int unsigned       ROUNDS = 32,
  parameter int unsigned       RPC    = 1,
  parameter logic [WORD_W-1:0] DELTA  = TEA_DELTA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [BLOCK_W-1:0] idata,
  input  logic [KEY_W-1:0]   key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] odata,
  output logic               busy
);

  localparam int unsigned N  = (RPC == 0) ? 1 : ROUNDS / RPC;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [WORD_W-1:0] SUM_DEC = DELTA * WORD_W'(ROUNDS);

  if (RPC == 0) begin : g_bad_rpc
    $error("tea_cipher_engine: RPC must be nonzero");
  end else if ((ROUNDS % RPC) != 0) begin : g_bad_div
    $error("tea_cipher_engine: ROUNDS must be divisible by RPC");
  end

  tea_state_e        state_q, state_d;
  logic              accept_c;
  logic              last_c;
  logic [CW-1:0]     cnt_q;
  logic [BLOCK_W-1:0] v_q;
  logic [KEY_W-1:0]  key_q;
  logic              mode_q;
  logic [WORD_W-1:0] sum_q;

  logic [BLOCK_W-1:0] v_chain   [RPC+1];
  logic [WORD_W-1:0]  sum_chain [RPC+1];

  assign v_chain[0]   = v_q;
  assign sum_chain[0] = sum_q;

  for (genvar i = 0; i < RPC; i++) begin : g_round
    tea_round_step #(.DELTA(DELTA)) u_step (
      .v_in    (v_chain[i]),
      .sum_in  (sum_chain[i]),
      .key     (key_q),
      .mode    (mode_q),
      .v_out   (v_chain[i+1]),
      .sum_out (sum_chain[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; in_ready lets a new block in during the output handshake
  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept_c = in_valid && in_ready;
    last_c   = (cnt_q == CW'(N - 1));
    case (state_q)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (last_c)   state_d = DONE;
      DONE:    if (out_ready) state_d = accept_c ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      odata     <= '0;
      cnt_q     <= '0;
      v_q       <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
      sum_q     <= '0;
    end else begin
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      if (accept_c) begin
        v_q    <= idata;
        key_q  <= key;
        mode_q <= mode;
        sum_q  <= mode ? SUM_DEC : '0;
        cnt_q  <= '0;
      end else if (state_q == RUN) begin
        v_q   <= v_chain[RPC];
        sum_q <= sum_chain[RPC];
        cnt_q <= cnt_q + CW'(1);
        if (last_c) odata <= v_chain[RPC];
      end
    end
  end

endmodule
